// File: rtl/dram_responder.sv
// dram_responder: wait-state data-memory responder for the core load/store port.
// One request in flight; ready is a registered one-cycle pulse WAIT_STATES+1
// cycles after accept. Optional per-byte even parity enabled by RAM_PARITY_EN.
module dram_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 2048,
   parameter int          WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ram_ce,
   input  logic        ram_we,
   input  logic [3:0]  ram_sel,
   input  logic [31:0] ram_addr,
   input  logic [31:0] ram_wdata,
   output logic [31:0] ram_rdata,
   output logic        ram_ready,
   output logic        ram_err
);
   localparam int          AW    = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WS    = 4'(WAIT_STATES);
   localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic [31:0] mem [DEPTH_WORDS];

   // request fields captured at accept; later input changes are ignored
   logic          lat_we, lat_ok;
   logic [3:0]    lat_sel;
   logic [AW-1:0] lat_idx;
   logic [31:0]   lat_wdata;

   logic [31:0]   offs;
   logic          in_range;
   logic [AW-1:0] idx;
   logic          accept, go_resp, wr_en, par_bad;
   logic          eff_we, eff_ok;
   logic [3:0]    eff_sel;
   logic [AW-1:0] eff_idx;
   logic [31:0]   eff_wdata;

   assign offs     = ram_addr - BASE_ADDR;
   assign in_range = (ram_addr >= BASE_ADDR) && ((offs >> 2) < DEPTH);
   assign idx      = offs[AW+1:2];

   // With zero wait states RESP is entered on the accept edge, so the live
   // inputs are used in IDLE and the latched copy everywhere else.
   assign eff_we    = (state == S_IDLE) ? ram_we    : lat_we;
   assign eff_ok    = (state == S_IDLE) ? in_range  : lat_ok;
   assign eff_sel   = (state == S_IDLE) ? ram_sel   : lat_sel;
   assign eff_idx   = (state == S_IDLE) ? idx       : lat_idx;
   assign eff_wdata = (state == S_IDLE) ? ram_wdata : lat_wdata;

   // a store commits on the edge entering RESP; never while reset is held
   assign wr_en = go_resp & eff_we & eff_ok & ~rst;

   // next-state and accept/complete strobes
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      go_resp   = 1'b0;
      case (state)
         S_IDLE: if (ram_ce) begin
            accept = 1'b1;
            if (WS == 4'd0) begin
               state_nxt = S_RESP;
               go_resp   = 1'b1;
            end else begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!ram_ce) begin
               state_nxt = S_IDLE;
            end else if (cnt == WS) begin
               state_nxt = S_RESP;
               go_resp   = 1'b1;
            end
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // state register, wait counter and request latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         lat_we    <= 1'b0;
         lat_ok    <= 1'b0;
         lat_sel   <= 4'd0;
         lat_idx   <= '0;
         lat_wdata <= 32'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt       <= 4'd1;
            lat_we    <= ram_we;
            lat_ok    <= in_range;
            lat_sel   <= ram_sel;
            lat_idx   <= idx;
            lat_wdata <= ram_wdata;
         end else if (state == S_WAIT && state_nxt == S_WAIT) begin
            cnt <= cnt + 4'd1;
         end else if (state_nxt == S_IDLE) begin
            cnt <= 4'd0;
         end
      end
   end

   // byte-lane memory write; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_en)
         for (int b = 0; b < 4; b++)
            if (eff_sel[b]) mem[eff_idx][8*b +: 8] <= eff_wdata[8*b +: 8];
   end

`ifdef RAM_PARITY_EN
   logic [3:0] par [DEPTH_WORDS];
   logic [31:0] rd_word;

   assign rd_word = mem[eff_idx];
   assign par_bad = |(par[eff_idx] ^ {^rd_word[31:24], ^rd_word[23:16],
                                      ^rd_word[15:8],  ^rd_word[7:0]});

   // even-parity bit per byte, written with its lane
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH_WORDS; i++) par[i] <= 4'd0;
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++)
            if (eff_sel[b]) par[eff_idx][b] <= ^eff_wdata[8*b +: 8];
      end
   end
`else
   assign par_bad = 1'b0;
`endif

   // registered response: data only for in-range loads, err with the pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_ready <= 1'b0;
         ram_err   <= 1'b0;
         ram_rdata <= 32'd0;
      end else begin
         ram_ready <= go_resp;
         ram_err   <= go_resp & (~eff_ok | (~eff_we & par_bad));
         ram_rdata <= (go_resp & ~eff_we & eff_ok) ? mem[eff_idx] : 32'd0;
      end
   end
endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: two responders (1 and 3 wait states) checked against a
// word-array reference model with randomized requests.
`timescale 1ns/1ps
module tb_dram_responder;
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 2048;
`ifdef RAM_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce0 = 1'b0, ce1 = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  sel = 4'd0;
   logic [31:0] addr = 32'd0, wdata = 32'd0;
   logic [31:0] rdata0, rdata1;
   logic        ready0, ready1, err0, err1;

   int total = 0;
   int bad   = 0;

   logic [31:0] mw [2][DEPTH];
   logic [3:0]  mp [2][DEPTH];

   always #5 clk = ~clk;

   dram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u0 (
      .clk(clk), .rst(rst), .ram_ce(ce0), .ram_we(we), .ram_sel(sel),
      .ram_addr(addr), .ram_wdata(wdata), .ram_rdata(rdata0),
      .ram_ready(ready0), .ram_err(err0));

   dram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u1 (
      .clk(clk), .rst(rst), .ram_ce(ce1), .ram_we(we), .ram_sel(sel),
      .ram_addr(addr), .ram_wdata(wdata), .ram_rdata(rdata1),
      .ram_ready(ready1), .ram_err(err1));

   function automatic int ws_of(input int w);
      return (w == 0) ? 1 : 3;
   endfunction

   function automatic logic [3:0] bpar(input logic [31:0] v);
      return {^v[31:24], ^v[23:16], ^v[15:8], ^v[7:0]};
   endfunction

   task automatic preload(input int w, input int i, input logic [31:0] v);
      if (w == 0) u0.mem[i] = v; else u1.mem[i] = v;
`ifdef RAM_PARITY_EN
      if (w == 0) u0.par[i] = bpar(v); else u1.par[i] = bpar(v);
`endif
      mw[w][i] = v;
      mp[w][i] = bpar(v);
   endtask

   // One complete request; expected response derived from the model before issue.
   task automatic do_req(input int w, input logic rwe, input logic [3:0] rsel,
                         input logic [31:0] ra, input logic [31:0] rwd, input string tag);
      logic        inr, rdy, er;
      logic [31:0] rd, erd;
      logic        eerr;
      int          i, lat;
      lat  = 1 + ws_of(w);
      inr  = (ra >= BASE) && (((ra - BASE) >> 2) < 32'(DEPTH));
      i    = int'(((ra - BASE) >> 2) & 32'(DEPTH - 1));
      erd  = (!rwe && inr) ? mw[w][i] : 32'd0;
      eerr = !inr || (!rwe && PAR && (mp[w][i] != bpar(mw[w][i])));
      @(negedge clk);
      we = rwe; sel = rsel; addr = ra; wdata = rwd;
      if (w == 0) ce0 = 1'b1; else ce1 = 1'b1;
      for (int c = 1; c <= lat; c++) begin
         @(posedge clk); #1;
         rdy = (w == 0) ? ready0 : ready1;
         rd  = (w == 0) ? rdata0 : rdata1;
         er  = (w == 0) ? err0   : err1;
         if (c == 1) begin
            // fields are latched at accept; scramble them to prove it
            we = ~rwe; sel = ~rsel; addr = $urandom; wdata = $urandom;
         end
         if (c < lat) begin
            total++;
            if (rdy !== 1'b0) begin bad++; $display("FAIL %s early_ready cycle=%0d got=%b want=0", tag, c, rdy); end
         end else begin
            total++;
            if (rdy !== 1'b1) begin bad++; $display("FAIL %s ready got=%b want=1", tag, rdy); end
            total++;
            if (rd !== erd) begin bad++; $display("FAIL %s rdata got=%h want=%h", tag, rd, erd); end
            total++;
            if (er !== eerr) begin bad++; $display("FAIL %s err got=%b want=%b", tag, er, eerr); end
         end
      end
      ce0 = 1'b0; ce1 = 1'b0;
      @(posedge clk); #1;
      rdy = (w == 0) ? ready0 : ready1;
      total++;
      if (rdy !== 1'b0) begin bad++; $display("FAIL %s ready_pulse_len got=%b want=0", tag, rdy); end
      if (rwe && inr)
         for (int b = 0; b < 4; b++)
            if (rsel[b]) begin
               mw[w][i][8*b +: 8] = rwd[8*b +: 8];
               mp[w][i][b]        = ^rwd[8*b +: 8];
            end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (ready0 !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%b want=0", ready0); end
      total++; if (err0 !== 1'b0)   begin bad++; $display("FAIL reset_err0 got=%b want=0", err0); end
      total++; if (rdata0 !== 32'd0) begin bad++; $display("FAIL reset_rdata0 got=%h want=0", rdata0); end
      total++; if (ready1 !== 1'b0) begin bad++; $display("FAIL reset_ready1 got=%b want=0", ready1); end
      total++; if (err1 !== 1'b0)   begin bad++; $display("FAIL reset_err1 got=%b want=0", err1); end
      total++; if (rdata1 !== 32'd0) begin bad++; $display("FAIL reset_rdata1 got=%h want=0", rdata1); end
      @(negedge clk);
      rst = 1'b0;
      for (int w = 0; w < 2; w++)
         for (int i = 0; i < DEPTH; i++) preload(w, i, $urandom);
   endtask

   task automatic test_load_basic;
      preload(0, 0, 32'h1);
      do_req(0, 1'b0, 4'hF, BASE, 32'd0, "load_w0");
      do_req(0, 1'b0, 4'b0001, BASE + 32'd40, 32'd0, "load_sel_indep");
      do_req(1, 1'b0, 4'hF, BASE + 32'd8, 32'd0, "load_ws3");
   endtask

   task automatic test_store_lanes;
      preload(0, 3, 32'h0);
      do_req(0, 1'b1, 4'b0110, BASE + 32'h0C, 32'hAABB_CCDD, "store_w3");
      total++;
      if (u0.mem[3] !== 32'h00BB_CC00) begin bad++; $display("FAIL store_w3_array got=%h want=00bbcc00", u0.mem[3]); end
      do_req(0, 1'b0, 4'hF, BASE + 32'h0C, 32'd0, "reload_w3");
      do_req(0, 1'b1, 4'b0000, BASE + 32'h10, $urandom, "store_sel0");
      do_req(0, 1'b0, 4'hF, BASE + 32'h10, 32'd0, "reload_sel0");
   endtask

   task automatic test_out_of_range;
      do_req(0, 1'b0, 4'hF, 32'h7FFF_FFFC, 32'd0, "oor_low");
      do_req(0, 1'b0, 4'hF, 32'h8000_2000, 32'd0, "oor_high");
      do_req(0, 1'b1, 4'hF, 32'h8000_2000, 32'hDEAD_BEEF, "oor_store_hi");
      do_req(0, 1'b1, 4'hF, 32'h7FFF_FFFC, 32'hCAFE_F00D, "oor_store_lo");
      do_req(0, 1'b0, 4'hF, BASE, 32'd0, "oor_alias_w0");
      do_req(0, 1'b0, 4'hF, BASE + 32'h1FFC, 32'd0, "oor_alias_top");
   endtask

   task automatic test_abort;
      @(negedge clk);
      we = 1'b1; sel = 4'hF; addr = BASE + 32'd4; wdata = ~mw[1][1]; ce1 = 1'b1;
      @(posedge clk); #1;
      total++; if (ready1 !== 1'b0) begin bad++; $display("FAIL abort_c1 got=%b want=0", ready1); end
      @(posedge clk); #1;
      total++; if (ready1 !== 1'b0) begin bad++; $display("FAIL abort_c2 got=%b want=0", ready1); end
      ce1 = 1'b0;
      for (int c = 3; c <= 6; c++) begin
         @(posedge clk); #1;
         total++; if (ready1 !== 1'b0) begin bad++; $display("FAIL abort_noready c=%0d got=%b want=0", c, ready1); end
      end
      total++;
      if (u1.mem[1] !== mw[1][1]) begin bad++; $display("FAIL abort_w1 got=%h want=%h", u1.mem[1], mw[1][1]); end
      do_req(1, 1'b0, 4'hF, BASE + 32'd4, 32'd0, "abort_reload");
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      we = 1'b1; sel = 4'hF; addr = BASE + 32'd20; wdata = ~mw[1][5]; ce1 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      total++; if (ready1 !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b want=0", ready1); end
      total++; if (err1 !== 1'b0)   begin bad++; $display("FAIL rstmid_err got=%b want=0", err1); end
      for (int w = 0; w < 2; w++)
         for (int i = 0; i < DEPTH; i++) mp[w][i] = 4'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      ce1 = 1'b0; rst = 1'b0;
      total++;
      if (u1.mem[5] !== mw[1][5]) begin bad++; $display("FAIL rstmid_w5 got=%h want=%h", u1.mem[5], mw[1][5]); end
      do_req(1, 1'b0, 4'hF, BASE + 32'd20, 32'd0, "rstmid_load_w5");
      do_req(1, 1'b1, 4'hF, BASE + 32'd20, 32'h0F0F_1234, "rstmid_store_w5");
      do_req(1, 1'b0, 4'hF, BASE + 32'd20, 32'd0, "rstmid_reload_w5");
   endtask

   task automatic test_parity;
      do_req(0, 1'b1, 4'hF, BASE + 32'd8, 32'h1234_5678, "par_store_w2");
      u0.mem[2] = u0.mem[2] ^ 32'h0000_0100;
      mw[0][2]  = mw[0][2] ^ 32'h0000_0100;
      do_req(0, 1'b0, 4'hF, BASE + 32'd8, 32'd0, "par_load_w2");
   endtask

   task automatic test_random;
      int          w;
      logic [31:0] ra;
      for (int n = 0; n < 80; n++) begin
         w = int'($urandom_range(0, 1));
         case ($urandom_range(0, 9))
            8:       ra = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 64));
            9:       ra = $urandom;
            default: ra = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
         endcase
         do_req(w, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ra, $urandom, "random");
      end
   endtask

   initial begin
      test_reset;
      test_load_basic;
      test_store_lanes;
      test_out_of_range;
      test_abort;
      test_reset_mid;
      test_parity;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
